uart_rx_top: RTL and testbench
==============================

// Module: uart_rx_top
// PURPOSE
//  Receive half of the 16550 UART: deserialises async line rx into data bytes using the
//  shared 16x oversampling baud_pulse, honouring LCR word length/parity settings.
//  Writes each completed character, with its error flags, toward the RX FIFO via a one-cycle push.
//  Counterpart of uart_tx_top; a uart_tx_top output looped to rx must reproduce its din.
// PARAMETERS
//  none (frame format fully runtime-selected through LCR inputs)
// PORTS
//  clk            in   1  system clock; single clock domain
//  rst            in   1  synchronous, active-high reset
//  baud_pulse     in   1  one-clk strobe, 16 per bit time
//  rx             in   1  serial line, idle high; asynchronous
//  pen            in   1  LCR parity enable
//  sticky_parity  in   1  LCR stick parity
//  eps            in   1  LCR even parity select
//  wls            in   2  LCR word length: 00=5,01=6,10=7,11=8 bits
//  push           out  1  one-clk pulse: dout/pe/fe/bi valid, write RX FIFO
//  dout           out  8  received char, LSB first on line; bits above length forced 0
//  pe             out  1  parity error for this char
//  fe             out  1  framing error (first stop bit sampled 0)
//  bi             out  1  break: data, parity (if pen) and stop all sampled 0
// BEHAVIOUR
//  - rx passes a 2-flop synchroniser (reset to 1); all logic uses synchronised rx_s.
//  - Reset: push=0, dout=0, pe=fe=bi=0, state=IDLE, count=0, bitcnt=0, rx_prev=1.
//  - All state/counter changes occur only on clk edges where baud_pulse=1, except
//    push, which drops after exactly one clk.
//  - IDLE: on baud_pulse, rx_prev<=rx_s; if rx_prev=1 && rx_s=0 -> START, count=0.
//    A line held low (break) never re-arms until rx_s returns high.
//  - START: count++ per baud_pulse; at count=7 (mid start bit) rx_s=1 -> IDLE
//    (false start, no push); rx_s=0 -> DATA, count=0, bitcnt=0.
//  - DATA: sample rx_s when count=15 (16 pulses after prior mid-point), shift into bit
//    [bitcnt], count wraps to 0; after bit (wls+4) -> PARITY if pen else STOP.
//  - PARITY: sample at count=15. Expected bit by {sticky_parity,eps}:
//    00 odd (~^data), 01 even (^data), 10 const 1, 11 const 0; mismatch -> pe.
//    data XOR covers only the wls-selected bits.
//  - STOP: sample first stop bit at count=15; fe = ~rx_s; bi = all sampled bits 0
//    (data, parity if pen, stop). In same clk: load dout/pe/fe/bi, push=1, -> IDLE.
//    Second stop bit is never checked; next start may be detected immediately.
//  - Latency: push asserts on the baud_pulse edge at mid-stop-bit, ~(1+N+P+0.5) bit
//    times after start edge (plus 2-clk synchroniser delay).
//  - dout/pe/fe/bi hold until next push; flags cleared on a clean char.
//  - Back-pressure absent: RX FIFO owns overrun detection; push is never stalled.
//  - wls/pen/eps/sticky_parity changes mid-frame: undefined frame, must not hang FSM.
//  - rst mid-frame: return to IDLE next clk, no push, partial data discarded.
// TESTING
//  Bench: baud_pulse 1 clk in every 6; bit time = 16 baud_pulses; drive rx by BFM.
//  1) wls=11,pen=0, send 0x13 8N1 -> exactly one push, dout=0x13, pe=fe=bi=0.
//  2) wls=11,pen=1,eps=1, send 0xA5 with parity 1 (wrong) -> push, dout=0xA5, pe=1;
//     repeat with parity 0 -> pe=0; sticky 10 with parity 0 -> pe=1.
//  3) wls=00, send 5-bit 0x15 then stop -> dout=0x15 (bits[7:5]=0), no error.
//  4) 8N1 0x55 with stop=0, rx high after -> dout=0x55, fe=1, bi=0; next 0x3C clean.
//  5) rx low for 3 char times -> one push, dout=0, fe=1, bi=1; no further push
//     until rx high; then 0x81 received clean.
//  6) rx low 4 baud_pulses then high -> no push; rst asserted mid-DATA -> no push,
//     next full 0xC3 frame received correctly; loopback from uart_tx_top matches din.

Source files
------------

// File: rtl/uart_rx_top.sv
// uart_rx_top: receive half of a 16550-style UART.
// Samples the asynchronous rx line with the shared 16x baud_pulse strobe and
// assembles 5..8 data bits, an optional parity bit and the first stop bit.
// Each completed character is presented for one clock on push, together
// with its parity, framing and break flags.
module uart_rx_top (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       rx,
  input  logic       pen,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic [1:0] wls,
  output logic       push,
  output logic [7:0] dout,
  output logic       pe,
  output logic       fe,
  output logic       bi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_meta_d;
  logic        rx_s_q, rx_s_d;
  logic        rx_prev_q, rx_prev_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  data_q, data_d;
  logic        par_bit_q, par_bit_d;
  logic        pe_flag_q, pe_flag_d;
  logic        push_q, push_d;
  logic [7:0]  dout_q, dout_d;
  logic        pe_q, pe_d;
  logic        fe_q, fe_d;
  logic        bi_q, bi_d;

  logic        mid_bit;
  logic        last_bit;
  logic [7:0]  word_mask;
  logic [7:0]  data_masked;
  logic        par_exp;

  // Sample instant: sixteen baud pulses after the previous mid-bit point.
  assign mid_bit  = baud_pulse && (count_q == 4'd15);
  // Final data bit index is word length minus one, i.e. wls + 4.
  assign last_bit = (bitcnt_q == ({1'b0, wls} + 3'd4));

  // Mask selecting the active data bits for the configured word length.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default on every path,
    // otherwise synthesis infers a latch to hold the previous value.
    word_mask = 8'hFF;
    case (wls)
      2'b00:   word_mask = 8'h1F;
      2'b01:   word_mask = 8'h3F;
      2'b10:   word_mask = 8'h7F;
      default: word_mask = 8'hFF;
    endcase
  end

  assign data_masked = data_q & word_mask;

  // Expected parity bit from stick/even select over the active data bits.
  always_comb begin
    par_exp = 1'b0;
    case ({sticky_parity, eps})
      2'b00:   par_exp = ~^data_masked;
      2'b01:   par_exp = ^data_masked;
      2'b10:   par_exp = 1'b1;
      default: par_exp = 1'b0;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      count_q   <= 4'd0;
      bitcnt_q  <= 3'd0;
      data_q    <= 8'h00;
      par_bit_q <= 1'b0;
      pe_flag_q <= 1'b0;
      push_q    <= 1'b0;
      dout_q    <= 8'h00;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      bi_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      rx_prev_q <= rx_prev_d;
      count_q   <= count_d;
      bitcnt_q  <= bitcnt_d;
      data_q    <= data_d;
      par_bit_q <= par_bit_d;
      pe_flag_q <= pe_flag_d;
      push_q    <= push_d;
      dout_q    <= dout_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      bi_q      <= bi_d;
    end
  end

  // Next-state logic; transitions only happen on baud_pulse edges.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (baud_pulse && rx_prev_q && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (baud_pulse && (count_q == 4'd7)) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (mid_bit && last_bit) state_d = pen ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (mid_bit) state_d = S_STOP;
      end
      S_STOP: begin
        if (mid_bit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values for each state.
  always_comb begin
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;
    rx_prev_d = rx_prev_q;
    count_d   = count_q;
    bitcnt_d  = bitcnt_q;
    data_d    = data_q;
    par_bit_d = par_bit_q;
    pe_flag_d = pe_flag_q;
    push_d    = 1'b0;
    dout_d    = dout_q;
    pe_d      = pe_q;
    fe_d      = fe_q;
    bi_d      = bi_q;

    // Edge history follows the line in every state, so a line still low
    // after a frame (break) cannot look like a fresh start edge.
    if (baud_pulse) rx_prev_d = rx_s_q;

    case (state_q)
      S_IDLE: begin
        if (baud_pulse) count_d = 4'd0;
      end
      S_START: begin
        if (baud_pulse) begin
          if (count_q == 4'd7) begin
            count_d   = 4'd0;
            bitcnt_d  = 3'd0;
            data_d    = 8'h00;
            par_bit_d = 1'b0;
            pe_flag_d = 1'b0;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (baud_pulse) count_d = count_q + 4'd1;
        if (mid_bit) begin
          data_d[bitcnt_q] = rx_s_q;
          bitcnt_d         = bitcnt_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (baud_pulse) count_d = count_q + 4'd1;
        if (mid_bit) begin
          par_bit_d = rx_s_q;
          pe_flag_d = rx_s_q ^ par_exp;
        end
      end
      S_STOP: begin
        if (baud_pulse) count_d = count_q + 4'd1;
        if (mid_bit) begin
          push_d = 1'b1;
          dout_d = data_masked;
          pe_d   = pen & pe_flag_q;
          fe_d   = ~rx_s_q;
          bi_d   = (data_masked == 8'h00) && !(pen && par_bit_q) && !rx_s_q;
        end
      end
      default: begin
        count_d = 4'd0;
      end
    endcase
  end

  assign push = push_q;
  assign dout = dout_q;
  assign pe   = pe_q;
  assign fe   = fe_q;
  assign bi   = bi_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Testbench for uart_rx_top: a line BFM drives serial frames, expected
// characters are queued when stimulus is issued and a monitor compares each
// push against the head of the queue.
module tb_uart_rx_top;

  localparam int BIT_CLKS = 96;  // 16 baud pulses x 6 clocks

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_pulse = 1'b0;
  logic       rx;
  logic       pen;
  logic       sticky_parity;
  logic       eps;
  logic [1:0] wls;
  logic       push;
  logic [7:0] dout;
  logic       pe;
  logic       fe;
  logic       bi;

  typedef struct packed {
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   baud_div = 0;

  uart_rx_top dut (
    .clk           (clk),
    .rst           (rst),
    .baud_pulse    (baud_pulse),
    .rx            (rx),
    .pen           (pen),
    .sticky_parity (sticky_parity),
    .eps           (eps),
    .wls           (wls),
    .push          (push),
    .dout          (dout),
    .pe            (pe),
    .fe            (fe),
    .bi            (bi)
  );

  always #5 clk = ~clk;

  // One baud pulse every six clocks.
  always @(posedge clk) begin
    if (baud_div == 5) begin
      baud_div   <= 0;
      baud_pulse <= 1'b1;
    end else begin
      baud_div   <= baud_div + 1;
      baud_pulse <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: every push must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (push === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_push: got dout 0x%02h pe %0b fe %0b bi %0b, expected no push",
                 dout, pe, fe, bi);
      end else begin
        e = sb.pop_front();
        check("dout", dout, e.dout);
        check("pe", {7'd0, pe}, {7'd0, e.pe});
        check("fe", {7'd0, fe}, {7'd0, e.fe});
        check("bi", {7'd0, bi}, {7'd0, e.bi});
      end
    end
  end

  task automatic bit_time();
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic expect_char(input logic [7:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    e.dout = d;
    e.pe   = p;
    e.fe   = f;
    e.bi   = b;
    sb.push_back(e);
  endtask

  // Start bit, nbits data LSB first, optional parity, one stop bit, one idle bit.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit has_par,
                            input bit par, input bit stop_bit);
    rx = 1'b0;
    bit_time();
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      bit_time();
    end
    if (has_par) begin
      rx = par;
      bit_time();
    end
    rx = stop_bit;
    bit_time();
    rx = 1'b1;
    bit_time();
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected pushes missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rx            = 1'b1;
    rst           = 1'b1;
    pen           = 1'b0;
    sticky_parity = 1'b0;
    eps           = 1'b0;
    wls           = 2'b11;
    repeat (4) @(negedge clk);
    check("reset_push", {7'd0, push}, 8'h00);
    check("reset_dout", dout, 8'h00);
    check("reset_flags", {5'd0, pe, fe, bi}, 8'h00);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_push", {7'd0, push}, 8'h00);

    // 8N1 clean character.
    expect_char(8'h13, 1'b0, 1'b0, 1'b0);
    send_frame(8'h13, 8, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_8n1");

    // 8E1: 0xA5 has four ones, even parity bit is 0.
    pen = 1'b1;
    eps = 1'b1;
    expect_char(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b1);
    expect_char(8'hA5, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    // Stick parity forced 1, line carries 0.
    sticky_parity = 1'b1;
    eps           = 1'b0;
    expect_char(8'hA5, 1'b1, 1'b0, 1'b0);
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_parity8");

    // 7O1: 0x41 has two ones, odd parity bit is 1.
    wls           = 2'b10;
    sticky_parity = 1'b0;
    eps           = 1'b0;
    expect_char(8'h41, 1'b0, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1);
    expect_char(8'h41, 1'b1, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    // Stick parity forced 0, line carries 0.
    sticky_parity = 1'b1;
    eps           = 1'b1;
    expect_char(8'h41, 1'b0, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1);
    wait_drain("drain_parity7");

    // 5N1: upper bits of dout stay zero.
    wls           = 2'b00;
    pen           = 1'b0;
    sticky_parity = 1'b0;
    eps           = 1'b0;
    expect_char(8'h15, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF5, 5, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_5n1");

    // Framing error, then a clean character.
    wls = 2'b11;
    expect_char(8'h55, 1'b0, 1'b1, 1'b0);
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
    expect_char(8'h3C, 1'b0, 1'b0, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_framing");

    // Break: line low for three character times gives a single push.
    expect_char(8'h00, 1'b0, 1'b1, 1'b1);
    rx = 1'b0;
    repeat (30) bit_time();
    rx = 1'b1;
    repeat (2) bit_time();
    wait_drain("drain_break");
    expect_char(8'h81, 1'b0, 1'b0, 1'b0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_after_break");

    // Glitch shorter than half a bit is rejected.
    rx = 1'b0;
    repeat (24) @(negedge clk);
    rx = 1'b1;
    repeat (3) bit_time();

    // Reset in the middle of the data bits discards the frame.
    rx = 1'b0;
    bit_time();
    rx = 1'b1;
    bit_time();
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("midframe_reset_dout", dout, 8'h00);
    repeat (12) bit_time();
    check("midframe_reset_idle", {7'd0, push}, 8'h00);

    expect_char(8'hC3, 1'b0, 1'b0, 1'b0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    wait_drain("drain_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
